// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl
//  Frame sequencer wrapped around a streaming sobel core. One raster frame
//  of ROW_SIZE*COL_SIZE pixels is passed to the core, one pixel per clock.
//  The controller then flushes the core pipeline and re-times the core
//  output into a framed stream with valid/last. Border pixels are forced to
//  zero. A consumed slot with no valid source pixel sets a sticky underrun
//  flag.
//
//  Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   start                 begin a frame (only honoured while idle)
//   in_valid, in_pixel    source pixel stream, raster order
//   in_ready              a pixel slot is consumed this cycle
//   core_reset            synchronous reset to the sobel core
//   core_pixel            pixel presented to the core
//   core_out              core gradient magnitude
//   out_valid, out_pixel,
//   out_last              framed, border-masked output stream
//   busy                  frame in progress
//   done                  one-cycle pulse after the last output
//   underrun              sticky; cleared when a new frame is started
module sobel_frame_ctrl #(
   parameter int WORD_SIZE = 8,
   parameter int ROW_SIZE  = 10,
   parameter int COL_SIZE  = 10,
   parameter int CORE_LAT  = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_pixel,
   output logic                 in_ready,
   output logic                 core_reset,
   output logic [WORD_SIZE-1:0] core_pixel,
   input  logic [WORD_SIZE-1:0] core_out,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_pixel,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 underrun
);

   localparam int N   = ROW_SIZE * COL_SIZE;
   // Input slot k reaches core_out (window centred on k) LAT cycles later.
   localparam int LAT = ROW_SIZE + 1 + CORE_LAT;
   localparam int CW  = $clog2(N + LAT + 2);
   localparam int XW  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
   localparam int YW  = $clog2(COL_SIZE + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                 state_reg, state_next;
   // Cycles since the first RUN cycle; spans RUN and FLUSH without a restart.
   logic [CW-1:0]          cyc_reg, cyc_next;
   logic [XW-1:0]          x_reg;
   logic [YW-1:0]          y_reg;
   logic                   underrun_reg;
   logic                   out_valid_reg;
   logic                   out_last_reg;
   logic [WORD_SIZE-1:0]   out_pixel_reg;

   logic                   capture;
   logic                   border;

   always_comb begin
      state_next = state_reg;
      cyc_next   = '0;
      in_ready   = 1'b0;
      core_reset = 1'b0;
      core_pixel = '0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            core_reset = 1'b1;
            busy       = 1'b0;
            if (start) state_next = S_CLEAR;
         end
         S_CLEAR: begin
            // Hold the core in reset for one extra cycle so its window starts clean.
            core_reset = 1'b1;
            state_next = S_RUN;
         end
         S_RUN: begin
            // The core cannot stall: a missing pixel is replaced by zero.
            in_ready   = 1'b1;
            core_pixel = in_valid ? in_pixel : '0;
            cyc_next   = cyc_reg + CW'(1);
            if (cyc_reg == CW'(N - 1)) state_next = S_FLUSH;
         end
         S_FLUSH: begin
            cyc_next = cyc_reg + CW'(1);
            if (cyc_reg == CW'(N + LAT)) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // core_out carries output index k = cyc_reg - LAT during this window.
   assign capture = ((state_reg == S_RUN) || (state_reg == S_FLUSH)) &&
                    (cyc_reg >= CW'(LAT)) && (cyc_reg <= CW'(LAT + N - 1));

   assign border  = (x_reg == '0) || (x_reg == XW'(ROW_SIZE - 1)) ||
                    (y_reg == '0) || (y_reg == YW'(COL_SIZE - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         cyc_reg       <= '0;
         x_reg         <= '0;
         y_reg         <= '0;
         underrun_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_pixel_reg <= '0;
      end else begin
         state_reg     <= state_next;
         cyc_reg       <= cyc_next;
         out_valid_reg <= capture;
         out_last_reg  <= capture && (cyc_reg == CW'(LAT + N - 1));
         out_pixel_reg <= (capture && !border) ? core_out : '0;

         if (state_reg == S_CLEAR) begin
            x_reg <= '0;
            y_reg <= '0;
         end else if (capture) begin
            if (x_reg == XW'(ROW_SIZE - 1)) begin
               x_reg <= '0;
               y_reg <= y_reg + YW'(1);
            end else begin
               x_reg <= x_reg + XW'(1);
            end
         end

         if ((state_reg == S_IDLE) && start)
            underrun_reg <= 1'b0;
         else if ((state_reg == S_RUN) && !in_valid)
            underrun_reg <= 1'b1;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign out_pixel = out_pixel_reg;
   assign underrun  = underrun_reg;

endmodule
